// File: rtl/mips_pkg.sv
// Shared definitions for the 5-stage MIPS pipeline: branch op encodings,
// stage-3 branch FSM states and the immediate-to-byte-offset helper.
package mips_pkg;

  localparam int OP_W     = 3;
  localparam int SQ_CNT_W = 4;

  localparam logic [OP_W-1:0] OP_NONE = 3'd0;
  localparam logic [OP_W-1:0] OP_BEQ  = 3'd1;
  localparam logic [OP_W-1:0] OP_BNE  = 3'd2;
  localparam logic [OP_W-1:0] OP_BLEZ = 3'd3;
  localparam logic [OP_W-1:0] OP_BGTZ = 3'd4;
  localparam logic [OP_W-1:0] OP_JREL = 3'd5;

  typedef enum logic {
    ST_IDLE   = 1'b0,
    ST_SQUASH = 1'b1
  } bu_state_e;

  // Signed word offset from the instruction, scaled to a byte offset.
  function automatic logic [31:0] word_to_byte_offset(input logic [15:0] imm);
    return {{14{imm[15]}}, imm, 2'b00};
  endfunction

endpackage

// File: rtl/branch_cond.sv
// Combinational branch condition evaluation. Kept separate so later
// forwarding and predictor logic can reuse the same decode.
module branch_cond
  import mips_pkg::*;
(
  input  logic [OP_W-1:0] op,
  input  logic [31:0]     rs,
  input  logic [31:0]     rt,
  output logic            take
);

  logic rs_eq_rt;
  logic rs_le_zero;

  assign rs_eq_rt   = (rs == rt);
  assign rs_le_zero = ($signed(rs) <= $signed(32'sd0));

  always_comb begin
    take = 1'b0;
    case (op)
      OP_BEQ:  take = rs_eq_rt;
      OP_BNE:  take = !rs_eq_rt;
      OP_BLEZ: take = rs_le_zero;
      OP_BGTZ: take = !rs_le_zero;
      OP_JREL: take = 1'b1;
      default: take = 1'b0;   // OP_NONE and the unused encodings 6, 7
    endcase
  end

endmodule

// File: rtl/branch_unit.sv
// Stage-3 branch resolution: issues a one-cycle relative branch request to the
// pc generator, holds squash over the wrong-path window, counts taken branches.
//
//   state     | meaning
//   ST_IDLE   | no wrong-path window open; a taken branch is accepted
//   ST_SQUASH | squash asserted; down-counter runs, new branches ignored
module branch_unit
  import mips_pkg::*;
#(
  parameter int unsigned SQUASH_CYCLES = 3,   // 1..15
  parameter int unsigned CNT_W         = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              id_valid,
  input  logic [OP_W-1:0]   id_op,
  input  logic [31:0]       id_rs,
  input  logic [31:0]       id_rt,
  input  logic [15:0]       id_imm,
  output logic              branch,
  output logic [31:0]       baddr,
  output logic              squash,
  output logic [CNT_W-1:0]  taken_count
);

  localparam logic [SQ_CNT_W-1:0] SQ_INIT = SQ_CNT_W'(SQUASH_CYCLES);
  localparam logic [SQ_CNT_W-1:0] SQ_LAST = SQ_CNT_W'(1);

  bu_state_e           state;
  bu_state_e           state_next;
  logic [SQ_CNT_W-1:0] sq_cnt;
  logic                take;
  logic                accept;

  branch_cond u_cond (
    .op   (id_op),
    .rs   (id_rs),
    .rt   (id_rt),
    .take (take)
  );

  always_comb begin
    state_next = state;
    squash     = 1'b0;
    accept     = 1'b0;
    case (state)
      ST_IDLE: begin
        accept = id_valid && take;
        if (accept) state_next = ST_SQUASH;
      end
      ST_SQUASH: begin
        squash = 1'b1;
        // Branches seen here are themselves wrong-path, so they never extend the window.
        if (sq_cnt == SQ_LAST) state_next = ST_IDLE;
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)                    sq_cnt <= '0;
    else if (accept)            sq_cnt <= SQ_INIT;
    else if (state == ST_SQUASH) sq_cnt <= sq_cnt - SQ_LAST;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      branch      <= 1'b0;
      baddr       <= '0;
      taken_count <= '0;
    end else if (accept) begin
      branch      <= 1'b1;
      baddr       <= word_to_byte_offset(id_imm);
      taken_count <= taken_count + CNT_W'(1);
    end else begin
      branch      <= 1'b0;
      baddr       <= '0;
    end
  end

endmodule
